// File: rtl/tdm_demux.sv
// Serial TDM receiver: hunts for frame sync, deserialises MSB-first words and tags each with its slot index.
// Word appears on dout/ch with a one-cycle valid pulse, one cycle after its last bit is sampled; no backpressure, en gates sampling.
module tdm_demux #(
  parameter int WIDTH = 4,
  parameter int CH_W  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic [CH_W-1:0]  ch,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  slot_q, slot_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             frame_start;
  logic             accept;
  logic             restart;
  logic [WIDTH-1:0] base_shift;
  logic [CNT_W-1:0] base_cnt;
  logic [CH_W-1:0]  base_slot;
  logic [WIDTH-1:0] word;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    dout_d      = dout_q;
    ch_d        = ch_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    accept      = 1'b0;
    restart     = 1'b0;
    frame_start = (cnt_q == '0) && (slot_q == '0);

    if (en) begin
      if (state_q == HUNT) begin
        if (sync) begin
          accept  = 1'b1;
          restart = 1'b1;
          state_d = RECV;
        end
      end else begin
        if (frame_start && !sync) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else if (sync && !frame_start) begin
          // Misplaced marker: drop the partial word and re-align on this bit.
          err_d   = 1'b1;
          accept  = 1'b1;
          restart = 1'b1;
        end else begin
          accept = 1'b1;
        end
      end
    end

    base_shift = restart ? '0 : shift_q;
    base_cnt   = restart ? '0 : cnt_q;
    base_slot  = restart ? '0 : slot_q;
    word       = (base_shift << 1) | WIDTH'(din);

    if (accept) begin
      if (base_cnt == LAST_BIT) begin
        dout_d  = word;
        ch_d    = base_slot;
        valid_d = !err_d;
        shift_d = '0;
        cnt_d   = '0;
        slot_d  = base_slot + CH_W'(1);
      end else begin
        shift_d = word;
        cnt_d   = base_cnt + CNT_W'(1);
        slot_d  = base_slot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      shift_q <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign dout   = dout_q;
  assign ch     = ch_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign locked = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: stimulus queues expected words, a forked monitor checks every valid pulse.
module tb_tdm_demux;
  localparam int WIDTH = 4;
  localparam int CH_W  = 1;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [CH_W-1:0]  c;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             din = 1'b0;
  logic             sync = 1'b0;
  logic [WIDTH-1:0] dout;
  logic [CH_W-1:0]  ch;
  logic             valid;
  logic             locked;
  logic             err;

  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(WIDTH), .CH_W(CH_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .din    (din),
    .sync   (sync),
    .dout   (dout),
    .ch     (ch),
    .valid  (valid),
    .locked (locked),
    .err    (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid || err) begin
        checks++;
        if (valid && err) begin
          errors++;
          $display("FAIL valid_with_err: valid=%b err=%b expected not both", valid, err);
        end
      end
      if (err) err_seen++;
      if (valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: dout=%b ch=%0d expected no word", dout, ch);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e.d || ch !== e.c) begin
            errors++;
            $display("FAIL word: dout=%b ch=%0d expected dout=%b ch=%0d", dout, ch, e.d, e.c);
          end
        end
      end
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge and held across the next one.
  task automatic drive(input logic e, input logic b, input logic s);
    en   = e;
    din  = b;
    sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic [CH_W-1:0] c,
                           input logic s, input bit gap);
    exp_t e;
    e.d = w;
    e.c = c;
    exp_q.push_back(e);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (gap) drive(1'b0, ~w[i], 1'b0);
      drive(1'b1, w[i], (i == WIDTH - 1) ? s : 1'b0);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_ch", 32'(ch), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) drive(1'b1, i[0], 1'b0);
    check("hunt_no_lock", 32'(locked), 32'h0);

    send_word(4'b1010, 1'b0, 1'b1, 1'b0);
    check("locked_frame1", 32'(locked), 32'h1);
    send_word(4'b0110, 1'b1, 1'b0, 1'b0);
    send_word(4'b1111, 1'b0, 1'b1, 1'b0);
    send_word(4'b0001, 1'b1, 1'b0, 1'b0);
    check("locked_frame2", 32'(locked), 32'h1);

    send_word(4'b1111, 1'b0, 1'b1, 1'b1);
    send_word(4'b0001, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    check("locked_gapped", 32'(locked), 32'h1);

    drive(1'b1, 1'b1, 1'b0);
    check("err_missing_sync", 32'(err), 32'h1);
    check("unlock_missing_sync", 32'(locked), 32'h0);
    drive(1'b1, 1'b1, 1'b0);
    check("err_one_cycle", 32'(err), 32'h0);
    for (int i = 0; i < 6; i++) drive(1'b1, i[1], 1'b0);
    check("still_hunting", 32'(locked), 32'h0);

    send_word(4'b1010, 1'b0, 1'b1, 1'b0);
    send_word(4'b0101, 1'b1, 1'b0, 1'b0);

    send_word(4'b0110, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("err_early_sync", 32'(err), 32'h1);
    check("locked_early_sync", 32'(locked), 32'h1);
    begin
      exp_t e;
      e.d = 4'b1011;
      e.c = 1'b0;
      exp_q.push_back(e);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    send_word(4'b1001, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    check("pre_reset_dout", 32'(dout), 32'h9);
    rst_n = 1'b0;
    #1;
    check("midreset_dout", 32'(dout), 32'h0);
    check("midreset_ch", 32'(ch), 32'h0);
    check("midreset_locked", 32'(locked), 32'h0);
    check("midreset_valid", 32'(valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, ~i[0], 1'b0);
    check("post_reset_unlocked", 32'(locked), 32'h0);

    send_word(4'b0011, 1'b0, 1'b1, 1'b0);
    send_word(4'b1100, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    check("words_outstanding", 32'(exp_q.size()), 32'h0);
    check("err_pulse_count", 32'(err_seen), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
